// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the program loader.
// No logic; types and constants only.
// Imported by the loader top.
package program_loader_pkg;

    // Frame start marker sent by the host before LEN.
    localparam logic [7:0] LOAD_HEADER = 8'hA5;

    // Instruction word width: {opcode, arg_a, arg_b}.
    localparam int WORD_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } load_state_e;

    // Byte-accepting states; DONE and ERR are single-cycle and refuse input.
    function automatic logic state_accepts(input load_state_e s);
        return (s == ST_IDLE) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/program_loader.sv
// Packs a framed host byte stream into 24-bit words and writes them to program ROM from address 0.
// Latency: ROM write strobe 1 cycle after a word's third byte; done/error pulse 1 cycle after CHK.
// Backpressure: in_ready low only in the one-cycle DONE/ERR states; no bubbles inside a frame.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int          ADDR_W  = 8,
    parameter int unsigned TIMEOUT = 65535,
    parameter int          TO_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 rom_w_enable,
    output logic [ADDR_W-1:0]    rom_w_addr,
    output logic [WORD_W-1:0]    rom_w_data,
    output logic                 cpu_halt,
    output logic                 busy,
    output logic                 load_done,
    output logic                 load_error
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    load_state_e         state_q, state_d;
    logic [7:0]          words_left_q, words_left_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [7:0]          chk_q, chk_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                halt_q, halt_d;
    logic                accept;

    assign in_ready     = state_accepts(state_q);
    assign accept       = in_valid && in_ready;
    assign busy         = (state_q != ST_IDLE);
    assign load_done    = (state_q == ST_DONE);
    assign load_error   = (state_q == ST_ERR);
    assign rom_w_enable = wen_q;
    assign rom_w_addr   = waddr_q;
    assign rom_w_data   = wdata_q;
    // Cleared on entry to DONE, so it drops in the same cycle as load_done.
    assign cpu_halt     = halt_q;

    // Next-state: frame parsing, word packing, checksum, idle timeout.
    always_comb begin
        state_d      = state_q;
        words_left_d = words_left_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        chk_d        = chk_q;
        to_cnt_d     = '0;
        wen_d        = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        halt_d       = halt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && (in_data == LOAD_HEADER)) begin
                    state_d = ST_LEN;
                    halt_d  = 1'b1;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (in_data == 8'h00) begin
                        state_d = ST_ERR;
                    end else begin
                        words_left_d = in_data;
                        word_idx_d   = '0;
                        byte_idx_d   = 2'd0;
                        chk_d        = in_data;
                        state_d      = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    chk_d = chk_q ^ in_data;
                    case (byte_idx_q)
                        2'd0: begin
                            wdata_d[23:16] = in_data;
                            byte_idx_d     = 2'd1;
                        end
                        2'd1: begin
                            wdata_d[15:8] = in_data;
                            byte_idx_d    = 2'd2;
                        end
                        default: begin
                            wdata_d[7:0] = in_data;
                            byte_idx_d   = 2'd0;
                            wen_d        = 1'b1;
                            waddr_d      = word_idx_q;
                            word_idx_d   = word_idx_q + 1'b1;
                            words_left_d = words_left_q - 8'd1;
                            if (words_left_q == 8'd1) begin
                                state_d = ST_CHECK;
                            end
                        end
                    endcase
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (in_data == chk_q) begin
                        state_d = ST_DONE;
                        halt_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            default: begin
                // DONE and ERR each last a single cycle.
                state_d = ST_IDLE;
            end
        endcase

        // Idle watchdog while a frame is open; a stalled host aborts the load.
        if ((state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHECK)) begin
            if (!accept) begin
                to_cnt_d = to_cnt_q + 1'b1;
                if ((TIMEOUT != 0) && (to_cnt_d == TO_LIMIT)) begin
                    state_d = ST_ERR;
                end
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            words_left_q <= 8'd0;
            word_idx_q   <= '0;
            byte_idx_q   <= 2'd0;
            chk_q        <= 8'd0;
            to_cnt_q     <= '0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_left_q <= words_left_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            chk_q        <= chk_d;
            to_cnt_q     <= to_cnt_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            halt_q       <= halt_d;
        end
    end

endmodule
